// File: rtl/pipe_adder_pkg.sv
// pipe_adder shared constants and the stage register bundle.
// Every stage register carries its own valid bit alongside the data.
package pipe_adder_pkg;

  localparam int PA_WIDTH = 16;
  localparam int PA_CHUNK = 4;

  typedef struct packed {
    logic                valid;
    logic                sub;
    logic                carry;
    logic                ovf;
    logic [PA_WIDTH-1:0] psum;
    logic [PA_WIDTH-1:0] a;
    logic [PA_WIDTH-1:0] b;
  } stage_t;

endpackage

// File: rtl/pipe_adder_chunk.sv
// adder_chunk: combinational CHUNK-bit ripple adder.
// o_cm is the carry into the chunk MSB, used for signed overflow.
module adder_chunk
  import pipe_adder_pkg::*;
#(
  parameter int CHUNK = PA_CHUNK
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_ci,
  output logic [CHUNK-1:0] o_s,
  output logic             o_co,
  output logic             o_cm
);

  logic w_c;

  always_comb begin
    w_c  = i_ci;
    o_s  = '0;
    o_cm = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) o_cm = w_c;
      o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c    = (i_a[i] & i_b[i]) |
               (w_c & (i_a[i] ^ i_b[i]));
    end
    o_co = w_c;
  end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: CHUNK bits per stage, valid/ready, stall-all pipeline.
// Define PIPE_ADDER_OVF_EN to build the signed-overflow output.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = PA_WIDTH,
  parameter int CHUNK = PA_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  // stage_t is sized by the package width
  if (WIDTH != PA_WIDTH || WIDTH % CHUNK != 0 || WIDTH < 4) begin : g_bad
    $error("pipe_adder: unsupported WIDTH/CHUNK");
  end

  stage_t            r_stg  [STAGES];
  stage_t            w_prev [STAGES];
  stage_t            w_nxt  [STAGES];
  stage_t            w_in;
  logic              w_adv;
  logic [STAGES-1:0] w_cm;
  logic              w_unused;

  function automatic stage_t f_step(
    input stage_t           p,
    input logic [CHUNK-1:0] s,
    input logic             co,
    input logic             ov,
    input int               k
  );
    stage_t n;
    n                         = p;
    n.carry                   = co;
    n.ovf                     = ov;
    n.psum[k*CHUNK +: CHUNK]  = s;
    return n;
  endfunction

  assign w_adv    = !r_stg[STAGES-1].valid || out_ready;
  assign in_ready = w_adv;

  always_comb begin
    w_in       = '0;
    w_in.valid = in_valid;
    w_in.sub   = sub;
    w_in.carry = sub | cin;
    w_in.a     = a;
    w_in.b     = sub ? ~b : b;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [CHUNK-1:0] w_s;
    logic             w_co;
    logic             w_ov;

    if (k == 0) begin : g_first
      assign w_prev[k] = w_in;
    end else begin : g_next
      assign w_prev[k] = r_stg[k-1];
    end

    adder_chunk #(.CHUNK(CHUNK)) u_add (
      .i_a  (w_prev[k].a[k*CHUNK +: CHUNK]),
      .i_b  (w_prev[k].b[k*CHUNK +: CHUNK]),
      .i_ci (w_prev[k].carry),
      .o_s  (w_s),
      .o_co (w_co),
      .o_cm (w_cm[k])
    );

`ifdef PIPE_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ov
      assign w_ov = w_cm[k] ^ w_co;
    end else begin : g_pass
      assign w_ov = w_prev[k].ovf;
    end
`else
    assign w_ov = 1'b0;
`endif

    assign w_nxt[k] = f_step(w_prev[k], w_s, w_co, w_ov, k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_stg[i] <= '0;
    end else if (w_adv) begin
      for (int i = 0; i < STAGES; i++) r_stg[i] <= w_nxt[i];
    end
  end

  assign out_valid = r_stg[STAGES-1].valid;
  assign sum       = r_stg[STAGES-1].psum;
  assign cout      = r_stg[STAGES-1].carry;
  assign ovf       = r_stg[STAGES-1].ovf;

  // operands and sub have no consumer after the final stage
  assign w_unused = ^{w_cm, r_stg[STAGES-1].a,
                      r_stg[STAGES-1].b, r_stg[STAGES-1].sub};

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=16, CHUNK=4).
// Honours PIPE_ADDER_OVF_EN when choosing the expected ovf.
module tb_pipe_adder;

`ifdef PIPE_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  pipe_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [17:0] e;
    int          cyc;
    bit          lat;
  } sb_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vt [10] = '{
    '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
    '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0},
    '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
    '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0},
    '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0}
  };

  sb_t         sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          n_stall = 0;
  bit          stall_prev = 0;
  logic [17:0] held;
  bit          rnd_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] x,
    input logic [15:0] y, input logic c, input logic s);
    logic [15:0] yy;
    logic [16:0] r;
    logic        v;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {16'd0, (s ? 1'b1 : c)};
    v  = (x[15] == yy[15]) && (r[15] != x[15]);
    return {r[15:0], r[16], v & OVF_ON};
  endfunction

  function automatic logic [17:0] vexp(input vec_t v);
    return {v.s, v.co, v.ov & OVF_ON};
  endfunction

  task automatic send(input logic [15:0] a_, input logic [15:0] b_,
    input logic c_, input logic s_, input logic [17:0] e, input bit lat);
    int n;
    bit done;
    n = 0;
    done = 0;
    a = a_; b = b_; cin = c_; sub = s_;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{e: e, cyc: cyc, lat: lat});
        done = 1;
      end else if (++n > 200) begin
        n_chk++; n_fail++;
        $display("FAIL send_timeout: in_ready stuck low");
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d results missing", sb.size());
    end
  endtask

  // monitor: output checks decoupled from stimulus
  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      if (stall_prev)
        check("hold", {13'd0, out_valid, sum, cout, ovf},
              {13'd0, 1'b1, held});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output: got %0h expected none",
                   {sum, cout, ovf});
        end else begin
          e = sb.pop_front();
          check("result", {14'd0, sum, cout, ovf}, {14'd0, e.e});
          if (e.lat) check("latency", cyc - e.cyc, 4);
        end
      end
      if (out_valid && !out_ready) begin
        check("in_ready_stall", {31'd0, in_ready}, 0);
        held = {sum, cout, ovf};
        stall_prev = 1;
        n_stall++;
      end else begin
        stall_prev = 0;
      end
    end else begin
      stall_prev = 0;
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_sum", {16'd0, sum}, 0);
    check("rst_cout_ovf", {30'd0, cout, ovf}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'd0, in_ready}, 1);
    @(posedge clk); #1;

    // directed vectors, consumer always ready
    for (int i = 0; i < 10; i++)
      send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vexp(vt[i]), 1);
    drain();

    // back-to-back with consumer stalled in cycles 6..9
    n_stall = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vexp(vt[i]), 0);
      end
      begin
        for (int c = 0; c < 16; c++) begin
          out_ready = !(c >= 6 && c <= 9);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_cycles", n_stall, 4);

    // reset with three results in flight
    for (int i = 0; i < 3; i++)
      send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vexp(vt[i]), 0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 0);
    check("flush_in_ready", {31'd0, in_ready}, 1);
    repeat (6) @(posedge clk);
    #1;
    send(vt[6].a, vt[6].b, vt[6].cin, vt[6].sub, vexp(vt[6]), 1);
    drain();

    // random traffic against the arithmetic model
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          logic [15:0] ra, rb;
          logic        rc, rs;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          ra = 16'($urandom);
          rb = 16'($urandom);
          rc = 1'($urandom);
          rs = 1'($urandom);
          send(ra, rb, rc, rs, model(ra, rb, rc, rs), 0);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width; SHALL be a multiple of CHUNK, minimum 4.
REQ-002 Parameter CHUNK, default 4: bits added per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port in_valid  in  1  operand set offered.
REQ-006 Port in_ready  out  1  operand set accepted when in_valid && in_ready.
REQ-007 Port a, b  in  WIDTH each  operands.
REQ-008 Port cin  in  1  carry-in; ignored when sub=1.
REQ-009 Port sub  in  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
REQ-010 Port out_valid  out  1  result present.
REQ-011 Port out_ready  in  1  consumer takes result when out_valid && out_ready.
REQ-012 Port sum  out  WIDTH  result, modulo 2^WIDTH.
REQ-013 Port cout  out  1  carry out of MSB; for sub, 1 means no borrow (a>=b unsigned).
REQ-014 Port ovf  out  1  signed two's-complement overflow (see Configuration).

Function
REQ-015 Stage k (0..STAGES-1) SHALL add operand bits [k*CHUNK +: CHUNK] using the registered carry from stage k-1; stage 0 uses cin (sub=0) or 1 (sub=1).
REQ-016 Higher operand chunks and lower result chunks SHALL be carried forward in stage registers so sum, cout, ovf emerge word-aligned.
REQ-017 Latency SHALL be exactly STAGES cycles from acceptance to out_valid with no stall; throughput one result per cycle.
REQ-018 advance = !out_valid || out_ready; in_ready SHALL equal advance; all stage registers SHALL load only when advance=1.
REQ-019 Each stage SHALL hold a valid bit; bubbles propagate and are not compressed.
REQ-020 While out_valid=1 and out_ready=0, sum/cout/ovf/out_valid SHALL hold stable.
REQ-021 Results SHALL leave in acceptance order; no result dropped or duplicated.
REQ-022 Simultaneous accept and output consume in one cycle SHALL both complete.

Reset
REQ-023 On rst=1 at a clock edge all stage valid bits, out_valid, sum, cout, ovf SHALL clear to 0, including mid-operation; in-flight results are discarded.
REQ-024 in_ready SHALL be 1 in the cycle after rst deasserts.

Configuration
REQ-025 Macro PIPE_ADDER_OVF_EN defined: ovf = carry into MSB XOR carry out of MSB, pipelined alongside sum.
REQ-026 Macro undefined: ovf port remains present, tied 0; no overflow logic synthesised.

Structure
REQ-027 Package pipe_adder_pkg SHALL hold default WIDTH and CHUNK constants and the stage-register struct typedef (valid, carry, partial sum, remaining operands, sub).
REQ-028 Sub-module adder_chunk SHALL implement one combinational CHUNK-bit ripple add (a, b, ci -> s, co, carry into MSB); pipe_adder instantiates STAGES copies and owns all registers.

Verification (WIDTH=16, CHUNK=4, STAGES=4)
REQ-029 a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x0100, cout=0, ovf=0.
REQ-030 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1 (ovf=0 without macro).
REQ-031 sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1 (with macro).
REQ-032 Back-to-back 8 operand sets, out_ready low cycles 6-9 -> in_ready low while output held, all 8 results in order, none lost.
REQ-033 rst pulsed with 3 results in flight -> out_valid=0 next cycle, no stale result ever emitted, new operand accepted and correct 4 cycles later.
REQ-034 Random a/b/cin/sub, random in_valid/out_ready, 10k transactions -> scoreboard matches a+b+cin or a-b modulo 2^16, with cout/ovf.
